// File: rtl/cordic_rotation_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC rotation core between NUM_REQ requesters.
// Define CORDIC_SCHED_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module cordic_rotation_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 16,
    parameter int HALF_TURN = 1800
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_x,
    input  logic [NUM_REQ*DATA_W-1:0]   req_y,
    input  logic [NUM_REQ*DATA_W-1:0]   req_angle,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_x,
    output logic [DATA_W-1:0]           rsp_y,
    output logic                        rsp_err,
    output logic                        core_reset,
    output logic [DATA_W-1:0]           core_x_in,
    output logic [DATA_W-1:0]           core_y_in,
    output logic [DATA_W-1:0]           core_angle,
    input  logic [DATA_W-1:0]           core_x_out,
    input  logic [DATA_W-1:0]           core_y_out
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic signed [DATA_W-1:0] HALF_S    = DATA_W'(HALF_TURN);
    localparam logic signed [DATA_W-1:0] QUARTER_S = DATA_W'(HALF_TURN / 2);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    typedef struct packed {
        logic                     err;
        logic                     flip;
        logic signed [DATA_W-1:0] angle;
    } red_t;

    // Two's complement negation; the most negative value wraps onto itself.
    function automatic logic signed [DATA_W-1:0] neg_wrap(input logic signed [DATA_W-1:0] v);
        return -v;
    endfunction

    function automatic red_t reduce_angle(input logic signed [DATA_W-1:0] a);
        red_t r;
        r.err   = 1'b0;
        r.flip  = 1'b0;
        r.angle = a;
        if (a > HALF_S || a < -HALF_S) begin
            r.err = 1'b1;
        end else if (a > QUARTER_S) begin
            r.flip  = 1'b1;
            r.angle = a - HALF_S;
        end else if (a < -QUARTER_S) begin
            r.flip  = 1'b1;
            r.angle = a + HALF_S;
        end
        return r;
    endfunction

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     grant_found;
    logic [ID_W-1:0]          grant_idx;
    logic                     accept;
    red_t                     red;
    logic [ID_W-1:0]          id_q;
    logic signed [DATA_W-1:0] x_q, y_q, ang_q;
    logic                     flip_q;
    logic signed [DATA_W-1:0] rsp_x_q, rsp_y_q;
    logic                     rsp_err_q;

`ifndef CORDIC_SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]          rr_ptr;
`endif

    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign red = reduce_angle(signed'(req_angle[grant_idx*DATA_W +: DATA_W]));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_nxt            = red.err ? RESP : LOAD;
                end
            end
            LOAD: state_nxt = WAIT;
            WAIT: if (wait_cnt == CNT_W'(LATENCY)) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Control: wait counter runs 1..LATENCY while in WAIT, pointer advances past each grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
`ifndef CORDIC_SCHED_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            if (state == LOAD)
                wait_cnt <= CNT_W'(1);
            else if (state == WAIT && wait_cnt != CNT_W'(LATENCY))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
`ifndef CORDIC_SCHED_FIXED_PRIO_EN
            if (accept)
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
        end
    end

    // Operands stay latched after the job so the core inputs remain stable through WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ang_q     <= '0;
            flip_q    <= 1'b0;
            rsp_x_q   <= '0;
            rsp_y_q   <= '0;
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            id_q      <= grant_idx;
            rsp_err_q <= red.err;
            if (red.err) begin
                rsp_x_q <= '0;
                rsp_y_q <= '0;
            end else begin
                x_q    <= signed'(req_x[grant_idx*DATA_W +: DATA_W]);
                y_q    <= signed'(req_y[grant_idx*DATA_W +: DATA_W]);
                ang_q  <= red.angle;
                flip_q <= red.flip;
            end
        end else if (state == WAIT && wait_cnt == CNT_W'(LATENCY)) begin
            rsp_x_q <= flip_q ? neg_wrap(signed'(core_x_out)) : signed'(core_x_out);
            rsp_y_q <= flip_q ? neg_wrap(signed'(core_y_out)) : signed'(core_y_out);
        end
    end

    assign core_reset = (state == LOAD);
    assign core_x_in  = x_q;
    assign core_y_in  = y_q;
    assign core_angle = ang_q;
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_q;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cordic_rotation_scheduler.sv
// Directed bench for cordic_rotation_scheduler: reduction/flip, error path, arbitration, backpressure, reset.
module tb_cordic_rotation_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_x, req_y, req_angle;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_x, rsp_y;
    logic         rsp_err;
    logic         core_reset;
    logic [31:0]  core_x_in, core_y_in, core_angle;
    logic [31:0]  core_x_out, core_y_out;

    int n_asrt = 0;
    int n_fail = 0;

    cordic_rotation_scheduler dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .core_reset(core_reset), .core_x_in(core_x_in), .core_y_in(core_y_in),
        .core_angle(core_angle), .core_x_out(core_x_out), .core_y_out(core_y_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] a);
        req_x[id*32 +: 32]     = x;
        req_y[id*32 +: 32]     = y;
        req_angle[id*32 +: 32] = a;
    endtask

    task automatic run_job(input int id, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] a, input logic [31:0] cx, input logic [31:0] cy,
                           input logic [31:0] e_ang, input logic [31:0] e_rx,
                           input logic [31:0] e_ry);
        int cnt;
        core_x_out = cx;
        core_y_out = cy;
        set_req(id, x, y, a);
        req_valid = 4'b0001 << id;
        #1;
        chk("grant", 32'(req_ready), 32'(4'b0001 << id));
        tick();
        req_valid = '0;
        chk("core_reset_hi", 32'(core_reset), 32'd1);
        chk("core_angle", core_angle, e_ang);
        chk("core_x_in", core_x_in, x);
        chk("core_y_in", core_y_in, y);
        chk("ready_in_load", 32'(req_ready), 32'd0);
        tick();
        chk("core_reset_lo", 32'(core_reset), 32'd0);
        cnt = 0;
        while (rsp_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("latency", 32'(cnt), 32'd16);
        chk("rsp_x", rsp_x, e_rx);
        chk("rsp_y", rsp_y, e_ry);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        logic [1:0] exp_g;
        reset      = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        req_angle  = '0;
        rsp_ready  = 1'b0;
        core_x_out = '0;
        core_y_out = '0;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_x", rsp_x, 32'd0);
        chk("rst_core_angle", core_angle, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        reset = 1'b0;
        tick();

        // no flip, then the two flip cases including the -180.0 boundary
        run_job(0, 0, 10, 900, 5, -7, 900, 5, 32'hFFFF_FFF9);
        run_job(1, 10, 0, 1350, 100, -200, 32'hFFFF_FE3E, 32'hFFFF_FF9C, 200);
        run_job(2, 3, 4, -1800, 32'h8000_0000, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);

        // out-of-range angle: response one cycle after accept, core untouched
        set_req(3, 9, 9, 1801);
        req_valid = 4'b1000;
        #1;
        chk("err_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_flag", 32'(rsp_err), 32'd1);
        chk("err_rsp_x", rsp_x, 32'd0);
        chk("err_rsp_y", rsp_y, 32'd0);
        chk("err_rsp_id", 32'(rsp_id), 32'd3);
        chk("err_core_reset", 32'(core_reset), 32'd0);
        chk("err_core_angle", core_angle, 32'd0);
        chk("err_core_x_in", core_x_in, 32'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // arbitration with all requesters held valid
        for (int i = 0; i < 4; i++) set_req(i, 0, 0, 1801);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
            exp_g = 2'd0;
`else
            exp_g = 2'(g % 4);
`endif
            #1;
            chk("arb_ready", 32'(req_ready), 32'(4'b0001 << exp_g));
            tick();
            chk("arb_rsp_id", 32'(rsp_id), 32'(exp_g));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        req_valid = '0;
        tick();

        // backpressure: response held, no grant while another requester waits
        set_req(1, 0, 0, 2000);
        set_req(2, 0, 0, -1801);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(rsp_id), 32'd1);
            chk("bp_rsp_err", 32'(rsp_err), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_regrant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("bp_second_id", 32'(rsp_id), 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset while the wait counter is at 8
        set_req(0, 1, 2, 450);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        for (int c = 0; c < 7; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_core_reset", 32'(core_reset), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_core_angle", core_angle, 32'd0);
        chk("mid_rst_core_x_in", core_x_in, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            seen |= rsp_valid;
            tick();
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        run_job(1, -5, 6, -900, 11, 22, -900, 11, 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_rotation_scheduler.md
Name: cordic_rotation_scheduler

Overview:
- Shares one iterative CORDIC rotation core between NUM_REQ requesters.
- Round-robin arbitration; one job in flight at a time.
- Pre-reduces each angle into the core's convergence range (±90.0°) and applies the matching 180° output negation.
- Returns each result to its requester over a shared response bus tagged with requester ID.
- Sits between the vector-processing clients and the CORDIC_Rotation core instance, and owns that core's reset/restart.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of x, y and angle words (two's complement).
- LATENCY, 16, cycles from core restart release to valid core outputs.
- HALF_TURN, 1800, 180.0° in angle units (units are tenths of a degree).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_x  in  NUM_REQ*DATA_W  packed x operands; requester i occupies slice [i*DATA_W +: DATA_W].
- req_y  in  NUM_REQ*DATA_W  packed y operands.
- req_angle  in  NUM_REQ*DATA_W  packed signed angles.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  clog2(NUM_REQ)  requester index of the response.
- rsp_x  out  DATA_W  rotated x.
- rsp_y  out  DATA_W  rotated y.
- rsp_err  out  1  angle out of range; x/y forced to 0.
- core_reset  out  1  restart pulse to the core.
- core_x_in  out  DATA_W  core x operand.
- core_y_in  out  DATA_W  core y operand.
- core_angle  out  DATA_W  reduced angle to the core.
- core_x_out  in  DATA_W  core x result.
- core_y_out  in  DATA_W  core y result.

Behaviour:
- Clock port is named clock; reset port is named reset. Reset is synchronous and active-high: sampled on the clock edge, no asynchronous path.
- Reset values:
  - All outputs 0, including core_reset.
  - State = IDLE; RR pointer = 0; wait counter = 0.
- States: IDLE -> LOAD -> WAIT -> RESP -> IDLE. An error job goes IDLE -> RESP directly.
- IDLE:
  - req_ready is one-hot for the first requester with req_valid set, searching from the RR pointer upward with wrap.
  - req_ready is 0 if no requester is valid and 0 in every other state.
  - Accept happens when req_valid[i] & req_ready[i]. On accept: latch id, x, y, angle; set pointer = i+1 (mod NUM_REQ).
- Angle reduction (signed, at accept):
  - |a| <= 900: core_angle = a; flip = 0.
  - 900 < a <= 1800: core_angle = a - 1800; flip = 1.
  - -1800 <= a < -900: core_angle = a + 1800; flip = 1.
  - |a| > 1800: error. Next state is RESP with rsp_err = 1 and rsp_x = rsp_y = 0; the core is untouched.
- LOAD (1 cycle):
  - core_reset = 1.
  - core_x_in, core_y_in and core_angle are driven with the latched operands and held stable until the job leaves WAIT.
- WAIT:
  - core_reset = 0; counter runs 1..LATENCY.
  - When the counter reaches LATENCY, capture core_x_out/core_y_out. If flip = 1, negate both (two's complement, wraps at DATA_W; -2^(DATA_W-1) maps to itself).
- RESP:
  - rsp_valid = 1; rsp_id/x/y/err are held stable until rsp_valid & rsp_ready.
  - Next state is IDLE, and rsp_valid drops the following cycle.
- Latency: accept at cycle T; core_reset high at T+1; rsp_valid first high at T+2+LATENCY. Error jobs: rsp_valid at T+1.
- Back-to-back: a new accept is possible in the first IDLE cycle after the response handshake. The maximum request rate is therefore one job per LATENCY+3 cycles.
- Simultaneous requests are resolved by RR order only. A requester may drop req_valid before grant without side effects.
- Reset mid-operation: the in-flight job is discarded with no response; core_reset returns to 0.

Optional Feature:
- Macro: CORDIC_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins; the RR pointer is removed.
- Undefined: round-robin as specified above.

Test Plan:
- Single job, no flip. Req0: x=0, y=10, angle=900 -> core_angle=900, core_x_in=0, core_y_in=10. Required: core_reset pulse at T+1; rsp_valid at T+18 (LATENCY=16); rsp_x/rsp_y equal core outputs; rsp_id=0; rsp_err=0.
- Flip path. x=10, y=0, angle=1350 -> core_angle=-450; rsp_x = -core_x_out, rsp_y = -core_y_out. Repeat with angle=-1800 -> core_angle=0, flip=1.
- Error. angle=1801 -> rsp_err=1, rsp_x=rsp_y=0 at T+1; core_reset never asserted.
- Arbitration. Req0..3 all held valid -> grants 0,1,2,3,0 in order. With CORDIC_SCHED_FIXED_PRIO_EN defined -> grants 0,0,0 while req0 stays valid.
- Backpressure. rsp_ready held 0 for 5 cycles -> rsp fields stable, no new grant; first req_ready appears 1 cycle after the handshake.
- Reset mid-WAIT. Assert reset at counter=8 -> next cycle all outputs 0, state IDLE, no rsp_valid for that job; a following job completes normally.
